// File: rtl/recv_arp_pkt.sv
// Receive-side ARP responder: parses the RX word stream, accepts ARP requests for
// the local IP, holds one reply descriptor and hands it to the ARP sender.
module recv_arp_pkt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_my_mac,
    input  logic [31:0] i_my_ip,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    input  logic        i_rx_vld,
    input  logic [31:0] i_rx_data,
    output logic        o_rx_rdy,
    input  logic        i_tx_ready,
    output logic        o_sync,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_arp_opcode,
    output logic [47:0] o_arp_sha,
    output logic [31:0] o_arp_spa,
    output logic [47:0] o_arp_tha,
    output logic [31:0] o_arp_tpa,
    output logic [15:0] o_req_cnt,
    output logic [7:0]  o_drop_cnt
);

    localparam int unsigned WCNT_W = 4;
    localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(10);

    typedef enum logic [1:0] {P_IDLE, P_HDR, P_SKIP} p_state_t;
    typedef enum logic [2:0] {S_EMPTY, S_PEND, S_FIRE, S_WLO, S_WHI} s_state_t;

    p_state_t           p_state, p_nxt;
    s_state_t           s_state, s_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic               ok, ok_nxt;
    logic               hi_bc, hi_bc_nxt, hi_my, hi_my_nxt;
    logic [47:0]        src_q, src_nxt, sha_q, sha_nxt;
    logic [31:0]        spa_q, spa_nxt;
    logic               w0_bc, w0_my, word_ok;
    logic               accept_c, capture_c, drop_c, sync_nxt;

    assign o_rx_rdy = 1'b1;

    // Parser: per-word header check, shadow capture, and end-of-frame evaluation
    always_comb begin
        p_nxt     = p_state;
        wcnt_nxt  = wcnt;
        ok_nxt    = ok;
        hi_bc_nxt = hi_bc;
        hi_my_nxt = hi_my;
        src_nxt   = src_q;
        sha_nxt   = sha_q;
        spa_nxt   = spa_q;
        accept_c  = 1'b0;
        w0_bc     = (i_rx_data[15:0] == 16'hFFFF);
        w0_my     = (i_rx_data[15:0] == i_my_mac[47:32]);
        word_ok   = 1'b1;
        case (wcnt)
            WCNT_W'(1):  word_ok = (hi_bc && (i_rx_data == 32'hFFFF_FFFF)) ||
                                   (hi_my && (i_rx_data == i_my_mac[31:0]));
            WCNT_W'(3):  word_ok = (i_rx_data[15:0] == 16'h0806);
            WCNT_W'(4):  word_ok = (i_rx_data == 32'h0001_0800);
            WCNT_W'(5):  word_ok = (i_rx_data == 32'h0604_0001);
            WCNT_W'(10): word_ok = (i_rx_data == i_my_ip);
            default:     word_ok = 1'b1;
        endcase
        if (i_rx_vld) begin
            if (i_rx_sop) begin
                // sop always (re)starts a frame, aborting any frame in progress
                wcnt_nxt  = WCNT_W'(1);
                ok_nxt    = w0_bc || w0_my;
                hi_bc_nxt = w0_bc;
                hi_my_nxt = w0_my;
                p_nxt     = i_rx_eop ? P_IDLE : P_HDR;
            end else begin
                case (p_state)
                    P_HDR: begin
                        ok_nxt   = ok && word_ok;
                        wcnt_nxt = wcnt + WCNT_W'(1);
                        case (wcnt)
                            WCNT_W'(2): src_nxt[47:16] = i_rx_data;
                            WCNT_W'(3): src_nxt[15:0]  = i_rx_data[31:16];
                            WCNT_W'(6): sha_nxt[47:16] = i_rx_data;
                            WCNT_W'(7): begin
                                sha_nxt[15:0]  = i_rx_data[31:16];
                                spa_nxt[31:16] = i_rx_data[15:0];
                            end
                            WCNT_W'(8): spa_nxt[15:0]  = i_rx_data[31:16];
                            default: ;
                        endcase
                        if (wcnt == LAST_W) begin
                            wcnt_nxt = wcnt;
                            if (i_rx_eop) begin
                                accept_c = ok && word_ok;
                                p_nxt    = P_IDLE;
                            end else begin
                                p_nxt    = P_SKIP;
                            end
                        end else if (i_rx_eop) begin
                            p_nxt = P_IDLE;
                        end
                    end
                    P_SKIP: begin
                        if (i_rx_eop) begin
                            accept_c = ok;
                            p_nxt    = P_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reply slot: one pending descriptor, sync pulse, then track the sender's ready
    always_comb begin
        s_nxt     = s_state;
        sync_nxt  = 1'b0;
        capture_c = accept_c && (s_state == S_EMPTY);
        drop_c    = accept_c && (s_state != S_EMPTY);
        case (s_state)
            S_EMPTY: if (capture_c) s_nxt = S_PEND;
            S_PEND: begin
                if (i_tx_ready) begin
                    sync_nxt = 1'b1;
                    s_nxt    = S_FIRE;
                end
            end
            S_FIRE:  s_nxt = S_WLO;
            S_WLO:   if (!i_tx_ready) s_nxt = S_WHI;
            S_WHI:   if (i_tx_ready) s_nxt = S_EMPTY;
            default: s_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_IDLE;
            s_state <= S_EMPTY;
            wcnt    <= '0;
            ok      <= 1'b0;
            hi_bc   <= 1'b0;
            hi_my   <= 1'b0;
            src_q   <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
        end else begin
            p_state <= p_nxt;
            s_state <= s_nxt;
            wcnt    <= wcnt_nxt;
            ok      <= ok_nxt;
            hi_bc   <= hi_bc_nxt;
            hi_my   <= hi_my_nxt;
            src_q   <= src_nxt;
            sha_q   <= sha_nxt;
            spa_q   <= spa_nxt;
        end
    end

    // Registered outputs: descriptor only changes on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sync       <= 1'b0;
            o_dst_mac    <= '0;
            o_src_mac    <= '0;
            o_arp_opcode <= '0;
            o_arp_sha    <= '0;
            o_arp_spa    <= '0;
            o_arp_tha    <= '0;
            o_arp_tpa    <= '0;
            o_req_cnt    <= '0;
            o_drop_cnt   <= '0;
        end else begin
            o_sync <= sync_nxt;
            if (capture_c) begin
                o_dst_mac    <= src_q;
                o_src_mac    <= i_my_mac;
                o_arp_opcode <= 16'h0002;
                o_arp_sha    <= i_my_mac;
                o_arp_spa    <= i_my_ip;
                o_arp_tha    <= sha_q;
                o_arp_tpa    <= spa_q;
                o_req_cnt    <= o_req_cnt + 16'd1;
            end
            if (drop_c && (o_drop_cnt != 8'hFF)) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_recv_arp_pkt.sv
// Scoreboard bench for recv_arp_pkt: expected replies queued at frame end, checked on each sync.
module tb_recv_arp_pkt;

    localparam logic [47:0] MY_MAC = 48'h02AA_BBCC_DD01;
    localparam logic [31:0] MY_IP  = 32'hC0A8_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_sop, rx_eop, rx_vld;
    logic [31:0] rx_data;
    logic        rx_rdy, tx_ready, sync;
    logic [47:0] dst_mac, src_mac, arp_sha, arp_tha;
    logic [15:0] arp_opcode, req_cnt;
    logic [31:0] arp_spa, arp_tpa;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    recv_arp_pkt dut (
        .clk(clk), .rst_n(rst_n), .i_my_mac(MY_MAC), .i_my_ip(MY_IP),
        .i_rx_sop(rx_sop), .i_rx_eop(rx_eop), .i_rx_vld(rx_vld), .i_rx_data(rx_data),
        .o_rx_rdy(rx_rdy), .i_tx_ready(tx_ready), .o_sync(sync),
        .o_dst_mac(dst_mac), .o_src_mac(src_mac), .o_arp_opcode(arp_opcode),
        .o_arp_sha(arp_sha), .o_arp_spa(arp_spa), .o_arp_tha(arp_tha), .o_arp_tpa(arp_tpa),
        .o_req_cnt(req_cnt), .o_drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [47:0] dst;
        logic [47:0] tha;
        logic [31:0] tpa;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          n_sync = 0;
    int          last_sync_cyc = 0;
    int          eop_cyc = 0;
    int          exp_req = 0;
    int          exp_drop = 0;
    logic        prev_sync = 1'b0;
    logic [31:0] frm [0:15];
    logic [47:0] cur_sha;
    logic [31:0] cur_spa;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sender model: drops ready for a few cycles after each sync unless muted or held
    int busy;
    bit tx_hold = 1'b0;
    bit tx_mute = 1'b0;
    assign tx_ready = !tx_hold && (busy == 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               busy <= 0;
        else if (busy != 0)       busy <= busy - 1;
        else if (sync && !tx_mute) busy <= 4;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sync) begin
                check("sync_width", 64'(prev_sync), 0);
                last_sync_cyc = cyc;
                n_sync++;
                if (sb.size() == 0) begin
                    check("unexpected_sync", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dst_mac", dst_mac, e.dst);
                    check("arp_tha", arp_tha, e.tha);
                    check("arp_tpa", arp_tpa, e.tpa);
                    check("src_mac", src_mac, MY_MAC);
                    check("arp_sha", arp_sha, MY_MAC);
                    check("arp_spa", arp_spa, MY_IP);
                    check("opcode", arp_opcode, 16'h0002);
                end
            end
            prev_sync = sync;
        end else begin
            prev_sync = 1'b0;
        end
    end

    task automatic mk(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] etype,
                      input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                      input logic [31:0] tpa);
        frm[0]  = {16'h0000, dst[47:32]};
        frm[1]  = dst[31:0];
        frm[2]  = src[47:16];
        frm[3]  = {src[15:0], etype};
        frm[4]  = 32'h0001_0800;
        frm[5]  = {16'h0604, op};
        frm[6]  = sha[47:16];
        frm[7]  = {sha[15:0], spa[31:16]};
        frm[8]  = {spa[15:0], 16'h0000};
        frm[9]  = 32'h0000_0000;
        frm[10] = tpa;
        for (int i = 11; i < 16; i++) frm[i] = $urandom;
        cur_sha = sha;
        cur_spa = spa;
    endtask

    task automatic mk_ok(input logic [47:0] sha, input logic [31:0] spa);
        mk(48'hFFFF_FFFF_FFFF, sha, 16'h0806, 16'h0001, sha, spa, MY_IP);
    endtask

    // kind: 0 = no reply, 1 = accepted reply, 2 = dropped (slot busy)
    task automatic send(input int n, input bit with_eop, input int kind);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0 && $urandom_range(0, 5) == 0) begin
                rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
                @(negedge clk);
            end
            rx_vld  = 1'b1;
            rx_sop  = (i == 0);
            rx_eop  = with_eop && (i == n - 1);
            rx_data = frm[i];
        end
        @(negedge clk);
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        eop_cyc = cyc;
        if (kind == 1) begin
            sb.push_back('{dst: cur_sha, tha: cur_sha, tpa: cur_spa});
            exp_req++;
        end else if (kind == 2) begin
            exp_drop++;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && !(sb.size() == 0 && busy == 0 && tx_ready); t++) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_req"}, req_cnt, 64'(exp_req));
        check({tag, "_drop"}, drop_cnt, 64'(exp_drop));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_sync", sync, 0);
        check("rst_dst", dst_mac, 0);
        check("rst_tha", arp_tha, 0);
        check("rst_tpa", arp_tpa, 0);
        check("rst_sha", arp_sha, 0);
        check("rst_op", arp_opcode, 0);
        check("rst_rdy", rx_rdy, 1);
        sb.delete();
        exp_req = 0;
        exp_drop = 0;
        check_cnts("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int n0;

    initial begin
        rst_n = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_vld = 1'b0; rx_data = '0;
        #1;
        check("init_sync", sync, 0);
        check("init_dst", dst_mac, 0);
        check("init_rdy", rx_rdy, 1);
        check_cnts("init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic broadcast request; sync two cycles after the eop cycle
        mk_ok(48'h0011_2233_4455, 32'hC0A8_0002);
        send(11, 1'b1, 1);
        wait_idle();
        check("sync_latency", 64'(last_sync_cyc - eop_cyc), 1);
        check_cnts("basic");

        // Requests that must be ignored
        mk(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4466, 16'h0806, 16'h0001, 48'h0011_2233_4466,
           32'hC0A8_0009, 32'hC0A8_0003);
        send(11, 1'b1, 0);
        mk(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4466, 16'h0806, 16'h0002, 48'h0011_2233_4466,
           32'hC0A8_0009, MY_IP);
        send(11, 1'b1, 0);
        mk(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4466, 16'h0800, 16'h0001, 48'h0011_2233_4466,
           32'hC0A8_0009, MY_IP);
        send(11, 1'b1, 0);
        mk(48'h02AA_BBCC_DD02, 48'h0011_2233_4466, 16'h0806, 16'h0001, 48'h0011_2233_4466,
           32'hC0A8_0009, MY_IP);
        send(11, 1'b1, 0);
        repeat (10) @(negedge clk);
        check_cnts("ignored");

        // Unicast to our MAC is accepted
        mk(MY_MAC, 48'h0011_2233_4477, 16'h0806, 16'h0001, 48'h0011_2233_4477,
           32'hC0A8_0010, MY_IP);
        send(11, 1'b1, 1);
        wait_idle();
        check_cnts("unicast");

        // Padded, short, and sop-aborted frames
        mk_ok(48'h0011_2233_5501, 32'hC0A8_0021);
        send(16, 1'b1, 1);
        wait_idle();
        mk_ok(48'h0011_2233_5502, 32'hC0A8_0022);
        send(8, 1'b1, 0);
        send(5, 1'b0, 0);
        mk_ok(48'h0011_2233_5503, 32'hC0A8_0023);
        send(11, 1'b1, 1);
        wait_idle();
        check_cnts("framing");

        // Second request while the first is pending is dropped; first is not overwritten
        tx_hold = 1'b1;
        mk_ok(48'h0011_2233_66AA, 32'hC0A8_0031);
        send(11, 1'b1, 1);
        mk_ok(48'h0011_2233_66BB, 32'hC0A8_0032);
        send(11, 1'b1, 2);
        repeat (5) @(negedge clk);
        check("pending_held", 64'(sb.size()), 1);
        check("not_overwritten", arp_tha, 48'h0011_2233_66AA);
        check_cnts("drop");
        tx_hold = 1'b0;
        wait_idle();

        // Sync is held off for 20 cycles of ready low
        tx_hold = 1'b1;
        n0 = n_sync;
        mk_ok(48'h0011_2233_7701, 32'hC0A8_0041);
        send(11, 1'b1, 1);
        repeat (20) @(negedge clk);
        check("held_no_sync", 64'(n_sync), 64'(n0));
        tx_hold = 1'b0;
        wait_idle();
        check("held_one_sync", 64'(n_sync), 64'(n0 + 1));
        check_cnts("held");

        // Reset mid-frame, then a normal frame
        mk_ok(48'h0011_2233_8801, 32'hC0A8_0051);
        send(7, 1'b0, 0);
        do_reset();
        mk_ok(48'h0011_2233_8802, 32'hC0A8_0052);
        send(11, 1'b1, 1);
        wait_idle();
        check_cnts("post_rst1");

        // Reset while waiting for the sender to start (ready never drops)
        tx_mute = 1'b1;
        n0 = n_sync;
        mk_ok(48'h0011_2233_9901, 32'hC0A8_0061);
        send(11, 1'b1, 1);
        for (int t = 0; t < 50 && n_sync == n0; t++) @(negedge clk);
        check("mute_sync", 64'(n_sync), 64'(n0 + 1));
        repeat (6) @(negedge clk);
        check("mute_no_repeat", 64'(n_sync), 64'(n0 + 1));
        do_reset();
        tx_mute = 1'b0;
        mk_ok(48'h0011_2233_9902, 32'hC0A8_0062);
        send(11, 1'b1, 1);
        wait_idle();
        check_cnts("post_rst2");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
